int_regfile_wr_port: RTL

// Integer register file (x0..x31) and its write-port responder. Accepts

---
 rtl/int_regfile_wr_port.sv | 134 +++++++++++++
 1 files changed

// File: rtl/int_regfile_wr_port.sv
// -----------------------------------------------------------------------------
// int_regfile_wr_port
// Integer register file (x0..x31) with its write-port arbiter. There is one
// write per cycle, shared between two sources:
//   - the core writeback path, which is fire-and-forget (no ack)
//   - multi-cycle units, which use a req/ack handshake
// The core has priority. If the core keeps a unit waiting for starve_limit
// cycles, the core is stalled for exactly one cycle and the unit is granted.
// The block also holds one pending bit per register. A launching multi-cycle
// op sets the bit, and the unit's writeback clears it.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   core_wr_req/sel/data      core writeback (valid this cycle, no ack)
//   core_stall                registered; core must hold writeback/issue
//   unit_wr_req/sel/data      unit write request, held until acked
//   unit_wr_ack               combinational accept, commits at this posedge
//   pend_set_req/sel0/sel1    mark up to two destinations pending (0 = none)
//   rd_sel_a/b                read selects
//   rd_data_a/b, rd_pend_a/b  combinational read data and pending bits
// -----------------------------------------------------------------------------
module int_regfile_wr_port #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5,
    parameter int starve_limit  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_wr_req,
    input  logic [reg_sel_width-1:0] core_wr_sel,
    input  logic [data_width-1:0]    core_wr_data,
    output logic                     core_stall,
    input  logic                     unit_wr_req,
    input  logic [reg_sel_width-1:0] unit_wr_sel,
    input  logic [data_width-1:0]    unit_wr_data,
    output logic                     unit_wr_ack,
    input  logic                     pend_set_req,
    input  logic [reg_sel_width-1:0] pend_set_sel0,
    input  logic [reg_sel_width-1:0] pend_set_sel1,
    input  logic [reg_sel_width-1:0] rd_sel_a,
    input  logic [reg_sel_width-1:0] rd_sel_b,
    output logic [data_width-1:0]    rd_data_a,
    output logic [data_width-1:0]    rd_data_b,
    output logic                     rd_pend_a,
    output logic                     rd_pend_b
);

    localparam int num_regs = 1 << reg_sel_width;
    localparam int cnt_w    = $clog2(starve_limit + 1);
    localparam logic [cnt_w-1:0] limit_c = cnt_w'(starve_limit);

    logic [data_width-1:0] regs_q [num_regs];
    logic [data_width-1:0] regs_d [num_regs];
    logic [num_regs-1:0]   pend_q, pend_d;
    logic [cnt_w-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  core_stall_q, core_stall_d;

    logic                  unit_grant;
    logic                  unit_commit;
    logic                  core_commit;

    // During a stall cycle the core's request is ignored, so the unit is
    // granted even with core_wr_req high.
    assign unit_grant  = unit_wr_req && (!core_wr_req || core_stall_q);
    // Reset gates the ack at once. A requester never sees an accept for a
    // write that the reset is about to discard.
    assign unit_wr_ack = unit_grant && rst;
    assign unit_commit = unit_grant;
    // unit_grant with core_wr_req high implies core_stall_q. So the core
    // commit cannot collide with a unit commit.
    assign core_commit = core_wr_req && !core_stall_q;

    assign core_stall  = core_stall_q;

    always_comb begin
        // Starvation counter: counts only cycles where the unit waits.
        starve_cnt_d = starve_cnt_q;
        if (!unit_wr_req || unit_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < limit_c) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        // The counter only reaches the limit while counting. It clears
        // during the stall cycle itself, so the stall lasts exactly one cycle.
        core_stall_d = (starve_cnt_d == limit_c);
    end

    always_comb begin
        regs_d = regs_q;
        if (unit_commit) begin
            regs_d[unit_wr_sel] = unit_wr_data;
        end else if (core_commit) begin
            regs_d[core_wr_sel] = core_wr_data;
        end
        // x0 is hardwired to zero. Writes to it are still acked above.
        regs_d[0] = '0;
    end

    always_comb begin
        pend_d = pend_q;
        if (unit_commit) begin
            pend_d[unit_wr_sel] = 1'b0;
        end
        // A set applied after the clear wins when both hit the same register.
        if (pend_set_req) begin
            if (pend_set_sel0 != '0) pend_d[pend_set_sel0] = 1'b1;
            if (pend_set_sel1 != '0) pend_d[pend_set_sel1] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < num_regs; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            starve_cnt_q <= '0;
            core_stall_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            pend_q       <= pend_d;
            starve_cnt_q <= starve_cnt_d;
            core_stall_q <= core_stall_d;
        end
    end

    // Reads have no bypass. A write is visible only after its commit edge.
    assign rd_data_a = regs_q[rd_sel_a];
    assign rd_data_b = regs_q[rd_sel_b];
    assign rd_pend_a = pend_q[rd_sel_a];
    assign rd_pend_b = pend_q[rd_sel_b];

endmodule
